dff_share_arbiter: RTL

Round-robin arbiter and write sequencer for a shared WIDTH-bit D flip-flop register. NREQ requesters compete for write access. The block grants one requester at a time, captures that requester's data into the shared register, and returns a one-cycle acknowledge. It sits between client blocks and the single storage register, so the register has exactly one writer per transfer.

---
 rtl/dff_share_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/dff_share_arbiter.sv
// rtl/dff_share_arbiter.sv - round-robin arbiter and write sequencer for a shared register
module dff_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   d,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        q,
    output logic [IDW-1:0]          owner,
    output logic                    valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [IDW-1:0]  PTR_INIT = IDW'(NREQ - 1);

    state_t         state;
    logic [IDW-1:0] ptr;      // last committed winner; search starts just after it
    logic [IDW-1:0] win;      // combinational winner of the current search
    logic [IDW-1:0] win_lat;  // winner held for the GRANT cycle

    // Winner search: scan ptr+NREQ down to ptr+1 so the nearest requester after ptr is written last and wins.
    always_comb begin
        win = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                win = IDW'(idx);
            end
        end
    end

    // Sequencer: IDLE arbitrates, GRANT commits or aborts, ACK pulses the acknowledge for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            owner   <= '0;
            valid   <= 1'b0;
            ptr     <= PTR_INIT;
            win_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        gnt     <= ONE_HOT0 << win;
                        win_lat <= win;
                        state   <= GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    if (req[win_lat]) begin
                        q     <= d[win_lat*WIDTH +: WIDTH];
                        owner <= win_lat;
                        valid <= 1'b1;
                        ptr   <= win_lat;
                        ack   <= ONE_HOT0 << win_lat;
                        state <= ACK;
                    end else begin
                        // Winner withdrew: nothing is committed and priority is not advanced.
                        ack   <= '0;
                        state <= IDLE;
                    end
                end
                ACK: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
